mc_ctrl: RTL and testbench

Multi-cycle control FSM for the PCOCD datapath. It sequences instruction fetch, decode, execute, memory access and write-back around the shared ALU, register file and unified memory. Each cycle it drives the ALU operation code, mux selects and write enables. It also stalls on the memory handshake and suppresses write-back on signed overflow.

---
 rtl/mc_ctrl_pkg.sv | 97 +++++++++
 rtl/mc_ctrl_if.sv | 40 ++++
 rtl/mc_ctrl_alu_op_dec.sv | 36 +++
 rtl/mc_ctrl.sv | 153 +++++++++++++++
 tb/tb_mc_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle controller: state encoding, opcode/funct
// values, ALU operation codes and the instruction classifier used by the FSM.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXE    = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Shared with the ALU; the numeric values are part of the datapath contract.
  typedef enum logic [2:0] {
    ALU_OP_ADD  = 3'd0,
    ALU_OP_SUB  = 3'd1,
    ALU_OP_AND  = 3'd2,
    ALU_OP_OR   = 3'd3,
    ALU_OP_LESS = 3'd4,
    ALU_OP_B    = 3'd5
  } alu_op_t;

  typedef enum logic [3:0] {
    C_RTYPE,
    C_ADDI,
    C_ADDIU,
    C_ORI,
    C_LW,
    C_SW,
    C_BEQ,
    C_J,
    C_ILLEGAL
  } iclass_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  function automatic iclass_t classify(input logic [5:0] op, input logic [5:0] funct);
    iclass_t c;
    c = C_ILLEGAL;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_SLT: c = C_RTYPE;
          default: c = C_ILLEGAL;
        endcase
      end
      OP_J:     c = C_J;
      OP_BEQ:   c = C_BEQ;
      OP_ADDI:  c = C_ADDI;
      OP_ADDIU: c = C_ADDIU;
      OP_ORI:   c = C_ORI;
      OP_LW:    c = C_LW;
      OP_SW:    c = C_SW;
      default:  c = C_ILLEGAL;
    endcase
    return c;
  endfunction

  // Only the trapping arithmetic forms may suppress write-back.
  function automatic logic ovf_checked(input logic [5:0] op, input logic [5:0] funct);
    return ((op == OP_RTYPE) && ((funct == FN_ADD) || (funct == FN_SUB))) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and status in, control strobes out.
// Memory handshake: mem_read/mem_write form a request held stable until the cycle
// mem_ready=1, which completes the access; mem_ready with no request is ignored.
interface mc_ctrl_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       overflow;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_op;
  logic [1:0] pc_source;
  logic [2:0] alu_op;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  op, funct, overflow, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_op,
           pc_source, alu_op, instr_done, illegal_op
  );

  modport slave (
    output op, funct, overflow, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, ext_op,
           pc_source, alu_op, instr_done, illegal_op
  );
endinterface

// File: rtl/mc_ctrl_alu_op_dec.sv
// ALU operation decoder: FETCH and DECODE always add (PC+4, branch target);
// EXE selects the instruction's own operation.
module alu_op_dec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [2:0] alu_op
);

  alu_op_t sel;

  always_comb begin
    sel = ALU_OP_ADD;
    if (state == S_EXE) begin
      case (classify(op, funct))
        C_RTYPE: begin
          case (funct)
            FN_SUB, FN_SUBU: sel = ALU_OP_SUB;
            FN_AND:          sel = ALU_OP_AND;
            FN_OR:           sel = ALU_OP_OR;
            FN_SLT:          sel = ALU_OP_LESS;
            default:         sel = ALU_OP_ADD;
          endcase
        end
        C_ORI:   sel = ALU_OP_OR;
        C_BEQ:   sel = ALU_OP_SUB;
        default: sel = ALU_OP_ADD;
      endcase
    end
  end

  assign alu_op = sel;

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: FETCH/DECODE/EXE/MEM/WB sequencing around a shared ALU
// and unified memory, with memory wait states and overflow-suppressed write-back.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_FETCH
) (
  input  logic              clk,
  input  logic              rst,
  mc_ctrl_if.master         bus,
  output state_t            dbg_state
);

  state_t     state_q;
  state_t     state_d;
  logic       ovf_q;
  logic       ovf_d;
  iclass_t    cls;
  ctl_t       ctl;
  logic [2:0] alu_op_w;

  assign cls = classify(bus.op, bus.funct);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RESET_STATE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  // Overflow is latched once per instruction, at the end of EXE.
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_EXE) begin
      ovf_d = ovf_checked(bus.op, bus.funct) & bus.overflow;
    end
  end

  always_comb begin
    ctl     = '0;
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'd1;
        ctl.ir_write  = bus.mem_ready;
        ctl.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctl.alu_src_b = 2'd3;
        ctl.ext_op    = 1'b1;
        case (cls)
          C_J: begin
            ctl.pc_write   = 1'b1;
            ctl.pc_source  = 2'd2;
            ctl.instr_done = 1'b1;
            state_d        = S_FETCH;
          end
          C_ILLEGAL: begin
            ctl.illegal_op = 1'b1;
            ctl.instr_done = 1'b1;
            state_d        = S_FETCH;
          end
          default: state_d = S_EXE;
        endcase
      end
      S_EXE: begin
        ctl.alu_src_a = 1'b1;
        case (cls)
          C_RTYPE: begin
            ctl.alu_src_b = 2'd0;
            state_d       = S_WB;
          end
          C_ADDI, C_ADDIU: begin
            ctl.alu_src_b = 2'd2;
            ctl.ext_op    = 1'b1;
            state_d       = S_WB;
          end
          C_ORI: begin
            ctl.alu_src_b = 2'd2;
            state_d       = S_WB;
          end
          C_LW, C_SW: begin
            ctl.alu_src_b = 2'd2;
            ctl.ext_op    = 1'b1;
            state_d       = S_MEM;
          end
          C_BEQ: begin
            ctl.alu_src_b     = 2'd0;
            ctl.pc_write_cond = 1'b1;
            ctl.pc_source     = 2'd1;
            ctl.instr_done    = 1'b1;
            state_d           = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        ctl.iord      = 1'b1;
        ctl.mem_read  = (cls == C_LW);
        ctl.mem_write = (cls == C_SW);
        if (bus.mem_ready) begin
          if (cls == C_LW) begin
            state_d = S_WB;
          end else begin
            ctl.instr_done = (cls == C_SW);
            state_d        = S_FETCH;
          end
        end else if ((cls != C_LW) && (cls != C_SW)) begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        ctl.reg_write  = ~ovf_q;
        ctl.instr_done = 1'b1;
        ctl.reg_dst    = (cls == C_RTYPE);
        ctl.mem_to_reg = (cls == C_LW);
        state_d        = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_op_dec u_alu_op_dec (
    .state  (state_q),
    .op     (bus.op),
    .funct  (bus.funct),
    .alu_op (alu_op_w)
  );

  assign bus.pc_write      = ctl.pc_write;
  assign bus.pc_write_cond = ctl.pc_write_cond;
  assign bus.iord          = ctl.iord;
  assign bus.mem_read      = ctl.mem_read;
  assign bus.mem_write     = ctl.mem_write;
  assign bus.ir_write      = ctl.ir_write;
  assign bus.reg_dst       = ctl.reg_dst;
  assign bus.mem_to_reg    = ctl.mem_to_reg;
  assign bus.reg_write     = ctl.reg_write;
  assign bus.alu_src_a     = ctl.alu_src_a;
  assign bus.alu_src_b     = ctl.alu_src_b;
  assign bus.ext_op        = ctl.ext_op;
  assign bus.pc_source     = ctl.pc_source;
  assign bus.alu_op        = alu_op_w;
  assign bus.instr_done    = ctl.instr_done;
  assign bus.illegal_op    = ctl.illegal_op;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction phase schedules from an instruction table,
// expected control words and latencies queued at issue, checked by a monitor.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;

  mc_ctrl_if bus();

  mc_ctrl #(.RESET_STATE(S_FETCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef enum int {K_R, K_ADDI, K_ADDIU, K_ORI, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;
  typedef enum int {P_F, P_D, P_E, P_M, P_W} phase_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    kind_t      k;
    logic [2:0] aop;
    bit         sens;
  } ins_t;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       asa;
    logic [1:0] asb;
    logic       ext;
    logic [1:0] psrc;
    logic [2:0] aop;
    logic       done;
    logic       ill;
  } cw_t;

  localparam int CW = $bits(cw_t);

  logic [CW-1:0] exp_q[$];
  int            lat_q[$];
  ins_t          tbl[$];
  int            total = 0;
  int            bad   = 0;
  bit            mon_en = 1'b0;
  int            cyc = 0;
  cw_t           mon_o;
  logic [CW-1:0] mon_e;
  int            mon_l;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic cw_t sample();
    cw_t w;
    w.st   = dbg_state;
    w.pcw  = bus.pc_write;
    w.pcwc = bus.pc_write_cond;
    w.iord = bus.iord;
    w.mrd  = bus.mem_read;
    w.mwr  = bus.mem_write;
    w.irw  = bus.ir_write;
    w.rdst = bus.reg_dst;
    w.m2r  = bus.mem_to_reg;
    w.rw   = bus.reg_write;
    w.asa  = bus.alu_src_a;
    w.asb  = bus.alu_src_b;
    w.ext  = bus.ext_op;
    w.psrc = bus.pc_source;
    w.aop  = bus.alu_op;
    w.done = bus.instr_done;
    w.ill  = bus.illegal_op;
    return w;
  endfunction

  // Control word the datapath should see in a given phase of an instruction.
  function automatic cw_t exp_word(input phase_t p, input ins_t i, input bit rdy, input bit ovf);
    cw_t w;
    w = '0;
    case (p)
      P_F: begin
        w.st = S_FETCH; w.mrd = 1'b1; w.asb = 2'd1; w.irw = rdy; w.pcw = rdy;
      end
      P_D: begin
        w.st = S_DECODE; w.asb = 2'd3; w.ext = 1'b1;
        if (i.k == K_J) begin w.pcw = 1'b1; w.psrc = 2'd2; w.done = 1'b1; end
        if (i.k == K_ILL) begin w.ill = 1'b1; w.done = 1'b1; end
      end
      P_E: begin
        w.st = S_EXE; w.asa = 1'b1;
        case (i.k)
          K_R:   begin w.asb = 2'd0; w.aop = i.aop; end
          K_ORI: begin w.asb = 2'd2; w.aop = 3'd3; end
          K_BEQ: begin w.asb = 2'd0; w.aop = 3'd1; w.pcwc = 1'b1; w.psrc = 2'd1; w.done = 1'b1; end
          default: begin w.asb = 2'd2; w.ext = 1'b1; end
        endcase
      end
      P_M: begin
        w.st = S_MEM; w.iord = 1'b1;
        w.mrd = (i.k == K_LW); w.mwr = (i.k == K_SW);
        w.done = (i.k == K_SW) && rdy;
      end
      default: begin
        w.st = S_WB; w.rw = ~ovf; w.done = 1'b1;
        w.rdst = (i.k == K_R); w.m2r = (i.k == K_LW);
      end
    endcase
    return w;
  endfunction

  // Builds the instruction's phase schedule, queues its expectations, then drives it.
  task automatic run_instr(input ins_t i, input int fw, input int mw, input bit ov);
    phase_t ph[$];
    bit     rq[$];
    bit     oe;
    for (int c = 0; c < fw; c++) begin ph.push_back(P_F); rq.push_back(1'b0); end
    ph.push_back(P_F); rq.push_back(1'b1);
    ph.push_back(P_D); rq.push_back(1'($urandom_range(0, 1)));
    if (i.k != K_J && i.k != K_ILL) begin
      ph.push_back(P_E); rq.push_back(1'($urandom_range(0, 1)));
      if (i.k == K_LW || i.k == K_SW) begin
        for (int c = 0; c < mw; c++) begin ph.push_back(P_M); rq.push_back(1'b0); end
        ph.push_back(P_M); rq.push_back(1'b1);
      end
      if (i.k != K_BEQ && i.k != K_SW) begin
        ph.push_back(P_W); rq.push_back(1'($urandom_range(0, 1)));
      end
    end
    oe = ov && i.sens;
    for (int c = 0; c < ph.size(); c++) exp_q.push_back(exp_word(ph[c], i, rq[c], oe));
    lat_q.push_back(ph.size());
    bus.op    = i.op;
    bus.funct = (i.op == 6'h00) ? i.funct : 6'($urandom_range(0, 63));
    for (int c = 0; c < ph.size(); c++) begin
      bus.mem_ready = rq[c];
      bus.overflow  = (ph[c] == P_E) ? ov : 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    if (!mon_en || !rst) begin
      cyc = 0;
    end else begin
      mon_o = sample();
      cyc++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL extra_cycle at %0t: got word %0h expected none", $time, mon_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ctl_word", 64'(mon_o), 64'(mon_e));
      end
      chk("rd_wr_excl", 64'(mon_o.mrd & mon_o.mwr), 64'd0);
      if (mon_o.done) begin
        if (lat_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done at %0t: got done=1 expected none", $time);
        end else begin
          mon_l = lat_q.pop_front();
          chk("latency", 64'(cyc), 64'(mon_l));
        end
        cyc = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back('{6'h00, 6'h20, K_R,     3'd0, 1'b1});  // 0 add
    tbl.push_back('{6'h00, 6'h21, K_R,     3'd0, 1'b0});  // 1 addu
    tbl.push_back('{6'h00, 6'h22, K_R,     3'd1, 1'b1});  // 2 sub
    tbl.push_back('{6'h00, 6'h23, K_R,     3'd1, 1'b0});  // 3 subu
    tbl.push_back('{6'h00, 6'h24, K_R,     3'd2, 1'b0});  // 4 and
    tbl.push_back('{6'h00, 6'h25, K_R,     3'd3, 1'b0});  // 5 or
    tbl.push_back('{6'h00, 6'h2A, K_R,     3'd4, 1'b0});  // 6 slt
    tbl.push_back('{6'h08, 6'h00, K_ADDI,  3'd0, 1'b1});  // 7 addi
    tbl.push_back('{6'h09, 6'h00, K_ADDIU, 3'd0, 1'b0});  // 8 addiu
    tbl.push_back('{6'h0D, 6'h00, K_ORI,   3'd3, 1'b0});  // 9 ori
    tbl.push_back('{6'h23, 6'h00, K_LW,    3'd0, 1'b0});  // 10 lw
    tbl.push_back('{6'h2B, 6'h00, K_SW,    3'd0, 1'b0});  // 11 sw
    tbl.push_back('{6'h04, 6'h00, K_BEQ,   3'd1, 1'b0});  // 12 beq
    tbl.push_back('{6'h02, 6'h00, K_J,     3'd0, 1'b0});  // 13 j
    tbl.push_back('{6'h3F, 6'h00, K_ILL,   3'd0, 1'b0});  // 14 op 0x3F
    tbl.push_back('{6'h05, 6'h00, K_ILL,   3'd0, 1'b0});  // 15 op 0x05
    tbl.push_back('{6'h00, 6'h00, K_ILL,   3'd0, 1'b0});  // 16 R-type funct 0x00
    tbl.push_back('{6'h00, 6'h26, K_ILL,   3'd0, 1'b0});  // 17 R-type funct 0x26

    // Reset held with memory ready: fetch outputs, ir/pc writes follow mem_ready.
    rst = 1'b0;
    bus.op = 6'h02; bus.funct = 6'h00; bus.overflow = 1'b0; bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_word", 64'(sample()), 64'(exp_word(P_F, tbl[13], 1'b1, 1'b0)));
    bus.mem_ready = 1'b0;
    #1;
    chk("reset_irw_follows", 64'(bus.ir_write), 64'd0);
    bus.mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_decode_j", 64'(sample()), 64'(exp_word(P_D, tbl[13], 1'b0, 1'b0)));
    @(posedge clk); #1;
    chk("post_j_fetch", 64'(dbg_state), 64'(S_FETCH));

    // Directed cases, then randomized traffic, all under the scoreboard.
    mon_en = 1'b1;
    run_instr(tbl[0], 0, 0, 1'b0);
    run_instr(tbl[0], 0, 0, 1'b1);
    run_instr(tbl[1], 0, 0, 1'b1);
    run_instr(tbl[2], 0, 0, 1'b1);
    run_instr(tbl[7], 1, 0, 1'b1);
    run_instr(tbl[10], 0, 3, 1'b0);
    run_instr(tbl[12], 0, 0, 1'b0);
    run_instr(tbl[13], 0, 0, 1'b0);
    run_instr(tbl[14], 0, 0, 1'b0);
    run_instr(tbl[11], 2, 2, 1'b0);
    for (int n = 0; n < 200; n++) begin
      run_instr(tbl[$urandom_range(0, tbl.size() - 1)], $urandom_range(0, 2),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    mon_en = 1'b0;
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("lat_q_drained", 64'(lat_q.size()), 64'd0);

    // Reset dropped during the memory phase of a store.
    bus.op = 6'h2B; bus.funct = 6'($urandom_range(0, 63)); bus.mem_ready = 1'b1; bus.overflow = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    #2;
    chk("sw_mem_state", 64'(dbg_state), 64'(S_MEM));
    chk("sw_mem_write", 64'(bus.mem_write), 64'd1);
    rst = 1'b0;
    #1;
    chk("abort_mem_write", 64'(bus.mem_write), 64'd0);
    chk("abort_state", 64'(dbg_state), 64'(S_FETCH));
    chk("abort_mem_read", 64'(bus.mem_read), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_hold_fetch", 64'(dbg_state), 64'(S_FETCH));

    mon_en = 1'b1;
    run_instr(tbl[0], 0, 0, 1'b0);
    run_instr(tbl[10], 1, 1, 1'b0);
    mon_en = 1'b0;
    chk("final_exp_q_drained", 64'(exp_q.size()), 64'd0);
    chk("final_lat_q_drained", 64'(lat_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
